// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg: shared types and defaults for the memory arbiter            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  localparam int c_timeout_default = 15;
  localparam int c_wait_w          = 4;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wait_counter: counts stalled memory cycles, flags the final one      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wait_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted on the stalled cycle whose edge makes the count reach LIMIT.
  assign o_terminal = i_enable && (r_count == c_last);

endmodule : wait_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter: shares one memory port between fetch and data accesses  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] if_addr,
  output logic [31:0]  if_rdata,
  input  logic         dm_read,
  input  logic         dm_write,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic [N-1:0] dm_rdata,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         timeout_err
);

  arb_state_t   r_state;
  arb_state_t   w_next;
  logic         r_fetch_done;
  logic         r_data_done;
  logic         r_first;
  logic         w_dm_req;
  logic         w_data_pend;
  logic         w_advance;
  logic         w_enter;
  logic         w_tc;
  logic [N-1:0] w_fetch_addr;
  logic         w_unused;

  assign w_dm_req     = dm_read | dm_write;
  assign w_data_pend  = w_dm_req & ~r_data_done;
  assign w_advance    = r_fetch_done & (r_data_done | ~w_dm_req) & (r_state != ERR);
  // ~stall is the enable for the fetch unit and the IF/ID/EX/MEM registers.
  assign stall        = ~w_advance;
  assign w_fetch_addr = {if_addr[N-1:3], 3'b000};
  assign w_enter      = (w_next != r_state) && ((w_next == DATA) || (w_next == FETCH));
  assign w_unused     = &{1'b0, if_addr[1:0]};

  wait_counter #(
    .WIDTH (c_wait_w),
    .LIMIT (TIMEOUT)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (reset),
    .i_clear    (w_enter),
    .i_enable   (mem_req & ~mem_ready),
    .o_terminal (w_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // Right after reset the first access must be a fresh fetch.
        if (w_data_pend && !r_first) w_next = DATA;
        else if (!r_fetch_done)      w_next = FETCH;
      end
      DATA: begin
        if (mem_ready) w_next = r_fetch_done ? IDLE : FETCH;
        else if (w_tc) w_next = ERR;
      end
      FETCH: begin
        if (mem_ready) w_next = w_data_pend ? DATA : IDLE;
        else if (w_tc) w_next = ERR;
      end
      default: w_next = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_fetch_done <= 1'b0;
      r_data_done  <= 1'b0;
      r_first      <= 1'b1;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      timeout_err  <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == ERR) timeout_err <= 1'b1;

      // Request fields load only on entry so they stay put until mem_ready.
      if (w_enter) begin
        mem_req <= 1'b1;
        if (w_next == DATA) begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_we    <= dm_write;
        end else begin
          mem_addr  <= w_fetch_addr;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
          r_first   <= 1'b0;
        end
      end else if ((w_next == IDLE) || (w_next == ERR)) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      case (r_state)
        DATA: begin
          if (mem_ready) begin
            r_data_done <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            r_fetch_done <= 1'b1;
            if_rdata     <= if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end
        IDLE: begin
          if (w_advance) begin
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : mem_arbiter
`default_nettype wire
